// File: rtl/shuffle_pkg.sv
// shuffle_pkg: shared state encoding and timing constants for the shuffle controller.
// Honours SHUFFLE_READ_WAIT_EN (one extra wait cycle after READ).
package shuffle_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_READ,
        S_READ_WAIT,
        S_SUM,
        S_SWAP,
        S_WR_SI,
        S_ADDR_SJ,
        S_WR_SJ,
        S_INC,
        S_DONE
    } state_e;

    localparam int ITER_COUNT_DEF = 256;

`ifdef SHUFFLE_READ_WAIT_EN
    localparam int CYCLES_PER_ITER = 8;
`else
    localparam int CYCLES_PER_ITER = 7;
`endif

endpackage

// File: rtl/shuffle_ctrl_fsm.sv
// shuffle_ctrl_fsm: sequences ITER_COUNT shuffle iterations, one control flag per cycle.
// Define SHUFFLE_READ_WAIT_EN to insert a READ_WAIT cycle for one-cycle-latency memory.
module shuffle_ctrl_fsm
    import shuffle_pkg::*;
#(
    parameter int ITER_COUNT = ITER_COUNT_DEF,
    localparam int IW = (ITER_COUNT > 1) ? $clog2(ITER_COUNT) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] iter_idx,
    output logic          read_s,
    output logic          read_key,
    output logic          sum_en,
    output logic          swap_en,
    output logic          wr_en_si,
    output logic          addr_to_sj,
    output logic          wr_en_sj,
    output logic          inc_en
);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE:      state_d = start ? S_READ : S_IDLE;
`ifdef SHUFFLE_READ_WAIT_EN
            S_READ:      state_d = S_READ_WAIT;
`else
            S_READ:      state_d = S_SUM;
`endif
            S_READ_WAIT: state_d = S_SUM;
            S_SUM:       state_d = S_SWAP;
            S_SWAP:      state_d = S_WR_SI;
            S_WR_SI:     state_d = S_ADDR_SJ;
            S_ADDR_SJ:   state_d = S_WR_SJ;
            S_WR_SJ:     state_d = S_INC;
            S_INC: begin
                // last iteration clears the index so the next pass starts at 0
                if (idx_q == IW'(ITER_COUNT - 1)) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end else begin
                    state_d = S_READ;
                    idx_d   = idx_q + 1'b1;
                end
            end
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    assign iter_idx   = idx_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign read_s     = (state_q == S_READ);
    assign read_key   = (state_q == S_READ);
    assign sum_en     = (state_q == S_SUM);
    assign swap_en    = (state_q == S_SWAP);
    assign wr_en_si   = (state_q == S_WR_SI);
    assign addr_to_sj = (state_q == S_ADDR_SJ);
    assign wr_en_sj   = (state_q == S_WR_SJ);
    assign inc_en     = (state_q == S_INC);

endmodule

// File: doc/shuffle_ctrl_fsm.md
SHUFFLE_CTRL_FSM -- requirements
Module: shuffle_ctrl_fsm

Interface
REQ-001 SHALL have parameter ITER_COUNT, default 256, meaning number of shuffle iterations (i = 0..ITER_COUNT-1).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to run one full shuffle pass.
REQ-005 SHALL have port busy  output  1  high from first READ cycle through last INC cycle.
REQ-006 SHALL have port done  output  1  one-cycle pulse when the pass completes.
REQ-007 SHALL have port iter_idx  output  $clog2(ITER_COUNT)  current iteration index i.
REQ-008 SHALL have ports read_s, read_key, sum_en, swap_en, wr_en_si, addr_to_sj, wr_en_sj, inc_en, each output 1, each the datapath control flag of the same name.

Function
REQ-009 SHALL implement states IDLE, READ, [READ_WAIT], SUM, SWAP, WR_SI, ADDR_SJ, WR_SJ, INC, DONE; each non-IDLE state lasts exactly one cycle.
REQ-010 SHALL transition IDLE->READ on a rising edge with start=1; otherwise remain in IDLE.
REQ-011 SHALL transition READ->SUM->SWAP->WR_SI->ADDR_SJ->WR_SJ->INC unconditionally, with READ_WAIT between READ and SUM only when configured (REQ-021).
REQ-012 SHALL transition INC->READ if iter_idx < ITER_COUNT-1, else INC->DONE; DONE->IDLE unconditionally.
REQ-013 SHALL assert exactly one flag per state: READ: read_s and read_key together; SUM: sum_en; SWAP: swap_en; WR_SI: wr_en_si; ADDR_SJ: addr_to_sj; WR_SJ: wr_en_sj; INC: inc_en; all flags 0 in IDLE, READ_WAIT, DONE.
REQ-014 SHALL drive flags as Moore outputs decoded from registered state, glitch-free, no combinational path from start.
REQ-015 SHALL increment iter_idx on the rising edge that leaves INC toward READ; SHALL clear iter_idx to 0 on leaving INC toward DONE.
REQ-016 SHALL ignore start in every state other than IDLE; start held high through DONE SHALL begin a new pass the cycle after returning to IDLE.
REQ-017 SHALL assert done only in DONE (single cycle); busy SHALL be 0 in IDLE and DONE.
REQ-018 SHALL complete a pass in 7*ITER_COUNT flag cycles (8*ITER_COUNT with wait), done in the following cycle (cycle 1793 after start edge for default, 2049 with wait).

Reset
REQ-019 SHALL on reset=1, asynchronously and at any time including mid-pass, force state IDLE, iter_idx=0, busy=0, done=0, all flags 0.
REQ-020 SHALL, after reset deasserts, require a fresh start in IDLE; no interrupted pass SHALL resume.

Configuration
REQ-021 SHALL, with macro SHUFFLE_READ_WAIT_EN defined, insert READ_WAIT (all flags 0, busy=1) between READ and SUM for one-cycle-latency memory; without it READ->SUM directly.

Structure
REQ-022 SHALL place the state enum typedef, the default ITER_COUNT constant and the per-iteration cycle count constant in shared package shuffle_pkg.
REQ-023 SHALL be a single module with no sub-module; counter and FSM are inline.

Verification
REQ-024 Reset idle: reset=1 then 0, start=0 for 20 cycles -> all outputs 0, iter_idx=0.
REQ-025 Single iteration sequence: ITER_COUNT=2, start pulse -> flags in order read_s+read_key, sum_en, swap_en, wr_en_si, addr_to_sj, wr_en_sj, inc_en, repeat once, then done=1 for one cycle, iter_idx back to 0.
REQ-026 Full pass: default ITER_COUNT, start pulse -> inc_en asserted exactly 256 times, done in cycle 1793 after start edge, iter_idx reached 255.
REQ-027 Start while busy: pulse start during SWAP of iteration 3 -> no change in sequence or iter_idx.
REQ-028 Reset mid-pass: assert reset in WR_SJ of iteration 10 between clock edges -> flags and busy drop to 0 immediately, iter_idx=0; next start runs full 256 iterations.
REQ-029 Wait build: SHUFFLE_READ_WAIT_EN defined, ITER_COUNT=2 -> one all-zero cycle between read_s and sum_en each iteration, done in cycle 17.
